// File: rtl/spi_init_sequencer.sv
// spi_init_sequencer: walks a 32-bit init table and issues one SPI frame per entry to a DAC or ADC.
// Optional macro SEQ_READBACK_VERIFY_EN adds a read-back and compare after every ADC write.
module spi_init_sequencer #(
  parameter int TBL_AW    = 8,
  parameter int BUSY_TMO  = 32,
  parameter int DLY_SHIFT = 6
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  output logic              dac_request_write,
  output logic [4:0]        dac_address,
  output logic [11:0]       dac_data,
  output logic              adc_request_write,
  output logic              adc_request_read,
  output logic [10:0]       adc_address,
  output logic [7:0]        adc_data,
  input  logic [7:0]        adc_data_readback,
  input  logic              busy,
  output logic              running,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [TBL_AW-1:0] err_index
);

  localparam int DLY_W = 12 + DLY_SHIFT;
  localparam int TMO_W = $clog2(BUSY_TMO + 1);

  localparam logic [1:0] OP_END = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_DAC = 2'b10;
  localparam logic [1:0] OP_DLY = 2'b11;

  localparam logic [1:0] E_TMO   = 2'b01;
  localparam logic [1:0] E_WRAP  = 2'b10;
  localparam logic [1:0] E_ABORT = 2'b11;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT_HI, WAIT_LO, DELAY,
`ifdef SEQ_READBACK_VERIFY_EN
    VERIFY,
`endif
    FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [1:0]        op_q, op_d;
  logic              dac_req_q, dac_req_d;
  logic [4:0]        dac_addr_q, dac_addr_d;
  logic [11:0]       dac_data_q, dac_data_d;
  logic              adc_wr_q, adc_wr_d;
  logic [10:0]       adc_addr_q, adc_addr_d;
  logic [7:0]        adc_data_q, adc_data_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [TBL_AW-1:0] err_index_q, err_index_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              abort_pend_q, abort_pend_d;
`ifdef SEQ_READBACK_VERIFY_EN
  logic              adc_rd_q, adc_rd_d;
  logic              rd_phase_q, rd_phase_d;
`endif

  logic              advance;
  logic              fail;
  logic [1:0]        fail_code;
  logic              unused_bits;

`ifdef SEQ_READBACK_VERIFY_EN
  assign unused_bits = ^{tbl_data[29:27], tbl_data[15:12]};
`else
  assign unused_bits = ^{tbl_data[29:27], tbl_data[15:12], adc_data_readback};
`endif

  always_comb begin
    state_d      = state_q;
    tbl_addr_d   = tbl_addr_q;
    op_d         = op_q;
    dac_req_d    = 1'b0;
    dac_addr_d   = dac_addr_q;
    dac_data_d   = dac_data_q;
    adc_wr_d     = 1'b0;
    adc_addr_d   = adc_addr_q;
    adc_data_d   = adc_data_q;
    running_d    = running_q;
    done_d       = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
    err_index_d  = err_index_q;
    dly_d        = dly_q;
    tmo_d        = tmo_q;
    abort_pend_d = abort_pend_q;
`ifdef SEQ_READBACK_VERIFY_EN
    adc_rd_d     = 1'b0;
    rd_phase_d   = rd_phase_q;
`endif
    advance      = 1'b0;
    fail         = 1'b0;
    fail_code    = E_ABORT;

    case (state_q)
      IDLE: begin
        // abort in the same cycle as start suppresses the run
        if (start && !abort) begin
          tbl_addr_d   = '0;
          running_d    = 1'b1;
          error_d      = 1'b0;
          err_code_d   = 2'b00;
          err_index_d  = '0;
          abort_pend_d = 1'b0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        if (abort) fail = 1'b1;
        else       state_d = DECODE;
      end
      DECODE: begin
        op_d       = tbl_data[31:30];
        adc_addr_d = tbl_data[26:16];
        adc_data_d = tbl_data[7:0];
        dac_addr_d = tbl_data[20:16];
        dac_data_d = tbl_data[11:0];
`ifdef SEQ_READBACK_VERIFY_EN
        rd_phase_d = 1'b0;
`endif
        if (abort) begin
          fail = 1'b1;
        end else begin
          case (tbl_data[31:30])
            OP_END: state_d = FINISH;
            OP_DLY: begin
              if (tbl_data[11:0] == 12'd0) begin
                advance = 1'b1;
              end else begin
                dly_d   = DLY_W'(tbl_data[11:0]) << DLY_SHIFT;
                state_d = DELAY;
              end
            end
            default: state_d = ISSUE;
          endcase
        end
      end
      ISSUE: begin
        if (abort) begin
          fail = 1'b1;
        end else if (!busy) begin
          tmo_d   = '0;
          state_d = WAIT_HI;
          if (op_q == OP_DAC)   dac_req_d = 1'b1;
`ifdef SEQ_READBACK_VERIFY_EN
          else if (rd_phase_q) adc_rd_d  = 1'b1;
`endif
          else                  adc_wr_d  = 1'b1;
        end
      end
      WAIT_HI: begin
        abort_pend_d = abort_pend_q | abort;
        if (busy) begin
          state_d = WAIT_LO;
        end else if (tmo_q == TMO_W'(BUSY_TMO - 1)) begin
          fail      = 1'b1;
          fail_code = E_TMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_LO: begin
        abort_pend_d = abort_pend_q | abort;
        // a requested abort is honoured only once the frame has fully drained
        if (!busy) begin
          if (abort_pend_q || abort) fail = 1'b1;
`ifdef SEQ_READBACK_VERIFY_EN
          else if (op_q == OP_ADC)  state_d = VERIFY;
`endif
          else                      advance = 1'b1;
        end
      end
      DELAY: begin
        if (abort)                     fail = 1'b1;
        else if (dly_q == DLY_W'(1))   advance = 1'b1;
        else                           dly_d = dly_q - DLY_W'(1);
      end
`ifdef SEQ_READBACK_VERIFY_EN
      VERIFY: begin
        if (abort) begin
          fail = 1'b1;
        end else if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
          state_d    = ISSUE;
        end else if (adc_data_readback != adc_data_q) begin
          fail      = 1'b1;
          fail_code = 2'b00;
        end else begin
          advance = 1'b1;
        end
      end
`endif
      FINISH: begin
        done_d       = 1'b1;
        running_d    = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (&tbl_addr_q) begin
        fail      = 1'b1;
        fail_code = E_WRAP;
      end else begin
        tbl_addr_d = tbl_addr_q + TBL_AW'(1);
        state_d    = FETCH;
      end
    end

    if (fail) begin
      error_d     = 1'b1;
      err_code_d  = fail_code;
      err_index_d = tbl_addr_q;
      state_d     = FINISH;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tbl_addr_q   <= '0;
      op_q         <= OP_END;
      dac_req_q    <= 1'b0;
      dac_addr_q   <= '0;
      dac_data_q   <= '0;
      adc_wr_q     <= 1'b0;
      adc_addr_q   <= '0;
      adc_data_q   <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'b00;
      err_index_q  <= '0;
      dly_q        <= '0;
      tmo_q        <= '0;
      abort_pend_q <= 1'b0;
`ifdef SEQ_READBACK_VERIFY_EN
      adc_rd_q     <= 1'b0;
      rd_phase_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tbl_addr_q   <= tbl_addr_d;
      op_q         <= op_d;
      dac_req_q    <= dac_req_d;
      dac_addr_q   <= dac_addr_d;
      dac_data_q   <= dac_data_d;
      adc_wr_q     <= adc_wr_d;
      adc_addr_q   <= adc_addr_d;
      adc_data_q   <= adc_data_d;
      running_q    <= running_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      err_index_q  <= err_index_d;
      dly_q        <= dly_d;
      tmo_q        <= tmo_d;
      abort_pend_q <= abort_pend_d;
`ifdef SEQ_READBACK_VERIFY_EN
      adc_rd_q     <= adc_rd_d;
      rd_phase_q   <= rd_phase_d;
`endif
    end
  end

  assign tbl_addr          = tbl_addr_q;
  assign dac_request_write = dac_req_q;
  assign dac_address       = dac_addr_q;
  assign dac_data          = dac_data_q;
  assign adc_request_write = adc_wr_q;
`ifdef SEQ_READBACK_VERIFY_EN
  assign adc_request_read  = adc_rd_q;
`else
  assign adc_request_read  = 1'b0;
`endif
  assign adc_address       = adc_addr_q;
  assign adc_data          = adc_data_q;
  assign running           = running_q;
  assign done              = done_q;
  assign error             = error_q;
  assign err_code          = err_code_q;
  assign err_index         = err_index_q;

endmodule

// File: doc/spi_init_sequencer.md
SPI_INIT_SEQUENCER -- requirements
Module: spi_init_sequencer

Interface
REQ-001 The block SHALL have parameter TBL_AW, default 8, meaning the init-table address width (2^TBL_AW entries).
REQ-002 The block SHALL have parameter BUSY_TMO, default 32, meaning the max sys_clk cycles from request pulse to busy rising.
REQ-003 The block SHALL have parameter DLY_SHIFT, default 6, meaning the delay-op scale (cycles = data << DLY_SHIFT).
REQ-004 The block SHALL have these ports: sys_clk  in  1  50 MHz clock, the one clock, all logic on its rising edge.
REQ-005 The block SHALL have these ports: reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have these ports: start  in  1  one-cycle pulse, run table from entry 0.
REQ-007 The block SHALL have these ports: abort  in  1  one-cycle pulse, stop after the current SPI frame.
REQ-008 The block SHALL have these ports: tbl_addr  out  TBL_AW  table address; tbl_data  in  32  entry, valid 1 cycle after tbl_addr.
REQ-009 The block SHALL have these ports: dac_request_write  out  1;  dac_address  out  5;  dac_data  out  12.
REQ-010 The block SHALL have these ports: adc_request_write  out  1;  adc_request_read  out  1;  adc_address  out  11;  adc_data  out  8.
REQ-011 The block SHALL have these ports: adc_data_readback  in  8;  busy  in  1  SPI controller busy.
REQ-012 The block SHALL have these ports: running  out  1;  done  out  1  one-cycle pulse;  error  out  1  sticky;  err_code  out  2;  err_index  out  TBL_AW.

Function
REQ-013 The entry format SHALL be: [31:30] op (00 END, 01 ADC write, 10 DAC write, 11 DELAY); [26:16] address; [11:0] data (ADC uses [7:0], DAC address uses [20:16]).
REQ-014 The states SHALL be IDLE, FETCH, DECODE, ISSUE, WAIT_HI, WAIT_LO, DELAY, VERIFY (macro only), FINISH.
REQ-015 On start in IDLE: tbl_addr<=0, running<=1, error/err_code cleared, then FETCH -> DECODE (1 cycle table latency).
REQ-016 DECODE: END -> FINISH; DELAY -> load counter data<<DLY_SHIFT, DELAY; write ops -> ISSUE.
REQ-017 ISSUE SHALL hold address/data stable and assert exactly one request for exactly one cycle, only in a cycle where busy=0; otherwise wait.
REQ-018 WAIT_HI SHALL wait for busy=1; if BUSY_TMO cycles elapse without it, set error, err_code=01, err_index=tbl_addr, go to FINISH.
REQ-019 WAIT_LO SHALL wait for busy=0, then increment tbl_addr and go to FETCH (or VERIFY for ADC writes when macro enabled).
REQ-020 DELAY SHALL count to zero (data=0 => zero extra cycles), then increment tbl_addr and FETCH.
REQ-021 If tbl_addr would wrap past 2^TBL_AW-1 without END, the block SHALL set error, err_code=10, and go to FINISH.
REQ-022 FINISH SHALL pulse done one cycle, clear running, return to IDLE; error remains until next start or reset.
REQ-023 start while running SHALL be ignored; start and abort in the same IDLE cycle: abort wins, no run.
REQ-024 abort during WAIT_HI/WAIT_LO SHALL take effect only after busy falls (no truncated frame); in other states it SHALL go to FINISH next cycle; err_code=11, error set.
REQ-025 Request/address/data outputs SHALL be registered; at most one request asserted in any cycle.

Reset
REQ-026 On reset: state IDLE; all request outputs 0; addresses/data 0; tbl_addr 0; running, done, error 0; err_code 00; err_index 0.
REQ-027 Reset mid-frame SHALL return to IDLE immediately; the sequencer SHALL NOT resume or re-issue.

Configuration
REQ-028 Macro SEQ_READBACK_VERIFY_EN: when defined, after each ADC write the block SHALL issue adc_request_read to the same address (same ISSUE/WAIT_HI/WAIT_LO rules), compare adc_data_readback to data[7:0], and on mismatch set error, err_code=11 reserved for abort replaced by mismatch flag via err_code=00 with error=1, err_index=entry, FINISH.
REQ-029 Without SEQ_READBACK_VERIFY_EN, no read is issued, adc_request_read is tied 0, VERIFY state is absent.

Verification
REQ-030 The bench SHALL cover: table {ADC wr 0x105/0xA5, END}, busy model 1-cycle rise, 24-cycle high -> one adc_request_write pulse, adc_address=0x105, adc_data=0xA5, done after busy fall + END decode.
REQ-031 The bench SHALL cover: DAC wr addr 0x13 data 0xFFF -> dac_address=0x13, dac_data=0xFFF, single pulse, no ADC request.
REQ-032 The bench SHALL cover: DELAY data=3, DLY_SHIFT=6 -> next fetch exactly 192 cycles after delay start.
REQ-033 The bench SHALL cover: busy stuck 0 -> error=1, err_code=01, err_index=0 after 32 cycles, done pulse.
REQ-034 The bench SHALL cover: abort asserted while busy=1 -> no request until busy=0, then done, err_code=11, running=0.
REQ-035 The bench SHALL cover (macro on): readback 0x5A vs written 0xA5 -> error=1, err_index=mismatching entry, no further requests.
